// File: rtl/seg_scan_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_if : display-data and scan-output bundle for seg_scan
// Revision    : 1.0
// ---------------------------------------------------------------------------
interface seg_scan_if;
    logic        enable;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic [7:0]  seg_n;
    logic [7:0]  dig_n;
    logic        frame_done;

    modport master (
        output enable, data, dp_mask,
        input  seg_n, dig_n, frame_done
    );

    modport slave (
        input  enable, data, dp_mask,
        output seg_n, dig_n, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan : 8-digit multiplexed common-anode 7-seg scanner, frame-shadowed.
//            Define SEG_SCAN_LZS_EN for leading-zero suppression.
// Revision : 1.0
// ---------------------------------------------------------------------------
module seg_scan #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  wire logic  clk,
    input  wire logic  rstn,
    seg_scan_if.slave  bus
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      data_sh_q, data_sh_d;
    logic [7:0]       dp_sh_q, dp_sh_d;
    logic [7:0]       seg_n_q, seg_n_d;
    logic [7:0]       dig_n_q, dig_n_d;
    logic             frame_done_q, frame_done_d;

    logic [3:0]       nib;
    logic [6:0]       seg_hex;
    logic             lz_blank;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_sh_d = data_sh_q;
        dp_sh_d   = dp_sh_q;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = BLANK;
                    cnt_d     = '0;
                    idx_d     = 3'd0;
                    data_sh_d = bus.data;
                    dp_sh_d   = bus.dp_mask;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST)
                        state_d = ON;
                end
                ON: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 3'd1;
                        // wrapping into digit 0 starts a new frame: resample inputs
                        if (idx_q == 3'd7) begin
                            data_sh_d = bus.data;
                            dp_sh_d   = bus.dp_mask;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        nib = data_sh_q[{idx_q, 2'b00} +: 4];
        case (nib)
            4'h0: seg_hex = 7'h3F;
            4'h1: seg_hex = 7'h06;
            4'h2: seg_hex = 7'h5B;
            4'h3: seg_hex = 7'h4F;
            4'h4: seg_hex = 7'h66;
            4'h5: seg_hex = 7'h6D;
            4'h6: seg_hex = 7'h7D;
            4'h7: seg_hex = 7'h07;
            4'h8: seg_hex = 7'h7F;
            4'h9: seg_hex = 7'h6F;
            4'hA: seg_hex = 7'h77;
            4'hB: seg_hex = 7'h7C;
            4'hC: seg_hex = 7'h39;
            4'hD: seg_hex = 7'h5E;
            4'hE: seg_hex = 7'h79;
            default: seg_hex = 7'h71;
        endcase
    end

`ifdef SEG_SCAN_LZS_EN
    // the current digit and everything above it are zero -> leading zero
    assign lz_blank = (idx_q != 3'd0) && ((data_sh_q >> {idx_q, 2'b00}) == 32'd0);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_n_d      = 8'hFF;
        dig_n_d      = 8'hFF;
        frame_done_d = 1'b0;
        if (bus.enable && (state_q == ON)) begin
            seg_n_d      = ~{dp_sh_q[idx_q], (lz_blank ? 7'h00 : seg_hex)};
            dig_n_d      = ~(8'h01 << idx_q);
            frame_done_d = (idx_q == 3'd7) && (cnt_q == SLOT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            data_sh_q    <= 32'd0;
            dp_sh_q      <= 8'd0;
            seg_n_q      <= 8'hFF;
            dig_n_q      <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_sh_q    <= data_sh_d;
            dp_sh_q      <= dp_sh_d;
            seg_n_q      <= seg_n_d;
            dig_n_q      <= dig_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan : randomized + directed self-checking bench for seg_scan
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_seg_scan;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 8 * CLK_DIV;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk;
    logic rstn;

    seg_scan_if bus_if ();

    seg_scan #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected segment byte for digit d given the frame's sampled data/dp.
    function automatic logic [7:0] seg_of(input int d, input logic [31:0] dat, input logic [7:0] dp);
        logic [6:0] s;
        logic [3:0] n;
        logic       lz;
        n  = dat[4*d +: 4];
        s  = HEX[n];
        lz = 1'b0;
`ifdef SEG_SCAN_LZS_EN
        lz = (d != 0);
        for (int j = d; j < 8; j++)
            if (dat[4*j +: 4] != 4'h0) lz = 1'b0;
`endif
        if (lz) s = 7'h00;
        return ~{dp[d], s};
    endfunction

    // Reference model: m_k counts cycles since the scan started, modulo one frame.
    logic        m_run  = 1'b0;
    int          m_k    = 0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp   = '0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [7:0]  exp_dig = 8'hFF;
    logic        exp_fd  = 1'b0;

    always @(posedge clk) begin
        if (!rstn || !bus_if.enable) begin
            m_run   <= 1'b0;
            exp_seg <= 8'hFF;
            exp_dig <= 8'hFF;
            exp_fd  <= 1'b0;
        end else if (!m_run) begin
            m_run   <= 1'b1;
            m_k     <= 0;
            m_data  <= bus_if.data;
            m_dp    <= bus_if.dp_mask;
            exp_seg <= 8'hFF;
            exp_dig <= 8'hFF;
            exp_fd  <= 1'b0;
        end else begin
            if ((m_k % CLK_DIV) >= BLANK_CYC) begin
                exp_seg <= seg_of(m_k / CLK_DIV, m_data, m_dp);
                exp_dig <= ~(8'h01 << (m_k / CLK_DIV));
                exp_fd  <= (m_k == FRAME - 1);
            end else begin
                exp_seg <= 8'hFF;
                exp_dig <= 8'hFF;
                exp_fd  <= 1'b0;
            end
            if (m_k == FRAME - 1) begin
                m_data <= bus_if.data;
                m_dp   <= bus_if.dp_mask;
            end
            m_k <= (m_k + 1) % FRAME;
        end
    end

    logic       chk_on = 1'b0;
    logic [7:0] cap [8];

    always @(negedge clk) begin
        if (chk_on) begin
            check("seg_n", {24'd0, bus_if.seg_n}, {24'd0, exp_seg});
            check("dig_n", {24'd0, bus_if.dig_n}, {24'd0, exp_dig});
            check("frame_done", {31'd0, bus_if.frame_done}, {31'd0, exp_fd});
            for (int i = 0; i < 8; i++)
                if (bus_if.dig_n == ~(8'h01 << i)) cap[i] <= bus_if.seg_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input string name, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc = cyc + 1;
        end while (!bus_if.frame_done && cyc < 4 * FRAME);
        check(name, {31'd0, bus_if.frame_done}, 32'd1);
    endtask

    task automatic wait_dig(input string name, input logic [7:0] pat);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc = cyc + 1;
        end while (bus_if.dig_n != pat && cyc < 4 * FRAME);
        check(name, {24'd0, bus_if.dig_n}, {24'd0, pat});
    endtask

    logic [7:0] lit_frame [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] lit_lz    [8];

    initial begin
        int cyc;
        int nfd;
        rstn           = 1'b0;
        bus_if.enable  = 1'b1;
        bus_if.data    = 32'h89AB_CDEF;
        bus_if.dp_mask = 8'h00;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("rst_seg", {24'd0, bus_if.seg_n}, 32'hFF);
            check("rst_dig", {24'd0, bus_if.dig_n}, 32'hFF);
            check("rst_fd", {31'd0, bus_if.frame_done}, 32'd0);
            if (c < 2) tick();
        end
        rstn = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("release_dig", {24'd0, bus_if.dig_n}, (c >= 4 && c <= 9) ? 32'hFE : 32'hFF);
        end

        wait_fd("fd_first", cyc);
        wait_fd("fd_second", cyc);
        check("frame_period", cyc, FRAME);
        for (int i = 0; i < 8; i++) check("frame_digit", {24'd0, cap[i]}, {24'd0, lit_frame[i]});

        bus_if.data    = 32'h0;
        bus_if.dp_mask = 8'h01;
        wait_fd("fd_dp_a", cyc);
        wait_fd("fd_dp_b", cyc);
        check("dp_digit0", {24'd0, cap[0]}, 32'h40);
        for (int i = 1; i < 8; i++) check("dp_other", {24'd0, cap[i]}, 32'hC0);

        bus_if.dp_mask = 8'h00;
        wait_fd("fd_tear_a", cyc);
        wait_fd("fd_tear_b", cyc);
        wait_dig("tear_dig3", 8'hF7);
        bus_if.data = 32'hFFFF_FFFF;
        wait_fd("fd_tear_c", cyc);
        for (int i = 0; i < 8; i++) check("tear_old", {24'd0, cap[i]}, 32'hC0);
        wait_fd("fd_tear_d", cyc);
        for (int i = 0; i < 8; i++) check("tear_new", {24'd0, cap[i]}, 32'h8E);

        wait_dig("drop_dig5", 8'hDF);
        tick();
        bus_if.enable = 1'b0;
        tick();
        check("drop_dig", {24'd0, bus_if.dig_n}, 32'hFF);
        check("drop_seg", {24'd0, bus_if.seg_n}, 32'hFF);
        nfd = 0;
        for (int c = 0; c < FRAME + 8; c++) begin
            tick();
            if (bus_if.frame_done) nfd = nfd + 1;
        end
        check("drop_no_fd", nfd, 0);

        bus_if.data   = 32'h0000_0120;
        bus_if.enable = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc = cyc + 1;
        end while (bus_if.dig_n == 8'hFF && cyc < 4 * FRAME);
        check("reenable_dig0", {24'd0, bus_if.dig_n}, 32'hFE);
        wait_fd("fd_lz", cyc);
`ifdef SEG_SCAN_LZS_EN
        lit_lz = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        lit_lz = '{8'hC0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        for (int i = 0; i < 8; i++) check("lz_digit", {24'd0, cap[i]}, {24'd0, lit_lz[i]});

        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(7) == 0) begin
                bus_if.data    = $urandom;
                bus_if.dp_mask = 8'($urandom);
            end
            if ($urandom_range(299) == 0) bus_if.enable = ~bus_if.enable;
            if (!bus_if.enable && $urandom_range(19) == 0) bus_if.enable = 1'b1;
        end
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Multiplexed scan driver for an 8-digit, common-anode seven-segment display. It sits directly downstream of the seg-LEDs CPU register block and consumes its 32-bit data word as eight hex nibbles. Each cycle it drives one digit's active-low segment pattern and active-low digit select. Every digit slot opens with a blanking interval to suppress ghosting. Input data is sampled once per frame, so a CPU write never tears a displayed frame.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot; must be greater than `BLANK_CYC`.
- `BLANK_CYC`, 16: cycles at the start of each slot with all digits off; must be at least 1.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `enable`  in  1  scan enable; 0 blanks the display.
- `data`  in  32  display value; nibble i (`data[4i+3:4i]`) goes to digit i.
- `dp_mask`  in  8  bit i lights the decimal point of digit i.
- `seg_n`  out  8  segment drive, active-low; bit 0..6 = a..g, bit 7 = dp.
- `dig_n`  out  8  digit select, active-low, one-hot-low; bit i = digit i.
- `frame_done`  out  1  one-cycle pulse at the end of each full 8-digit frame.

## Operation
- **States:**
  - IDLE: display off, digit index 0, slot counter 0.
  - BLANK: digit selected internally but `dig_n` = FF.
  - ON: digit driven.
- **Transitions:**
  - IDLE→BLANK when `enable` = 1.
  - BLANK→ON when slot counter = `BLANK_CYC`-1.
  - ON→BLANK when slot counter = `CLK_DIV`-1. Slot counter clears and the digit index increments mod 8.
  - Any state→IDLE when `enable` = 0, which takes priority.
- **Shadow registers:** `data` and `dp_mask` are copied into shadow registers on every entry to BLANK with digit index 0. All decode uses the shadow copies only.
- **Hex decode (active-high a..g), digit 0..F:** 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- **Output assembly:** `seg_n` = ~{dp_shadow[i], decode(nibble i)}.
- **Segment drive in IDLE and BLANK:** `seg_n` = FF.
- **Digit select in ON:** `dig_n` = ~(8'b1 << i).
- **Frame end:** after digit 7 ON, the index wraps to 0 and the shadow reloads.

## Timing
- **Reset values:** `seg_n` = 8'hFF, `dig_n` = 8'hFF, `frame_done` = 0. Internal state is IDLE, index 0, counter 0, shadows 0.
- **Reset mid-slot:** outputs take their reset values at the first `clk` edge sampling `rstn` = 0. They stay there while `rstn` = 0.
- **Registered outputs:** all outputs are registered and reflect the state and index one cycle after the state register.
- **Enable rise:** `enable` sampled 1 in IDLE, then BLANK for digit 0 begins the next cycle. `dig_n[0]` goes low `BLANK_CYC` cycles later, plus 1 cycle of output latency.
- **Slot length:** each digit slot is exactly `CLK_DIV` cycles: `BLANK_CYC` blank, then `CLK_DIV`-`BLANK_CYC` on.
- **Frame length:** 8×`CLK_DIV` cycles.
- **`frame_done`:** high for exactly one cycle, aligned with the last ON output cycle of digit 7.
- **Enable fall:** `enable` sampled 0 forces IDLE. Outputs read FF on the following cycle. There is no partial-frame `frame_done`.
- **Input change mid-frame:** a change of `data` or `dp_mask` has no visible effect until the next frame's digit-0 BLANK entry.
- **Digit overlap:** no two `dig_n` bits are ever low in the same cycle. Between consecutive digits there are at least `BLANK_CYC` cycles with `dig_n` = FF.

## Configuration
- **Macro:** `SEG_SCAN_LZS_EN` enables leading-zero suppression.
- **Defined:** digit i (7..1) has its segments a..g forced off when nibbles 7..i of the shadow are all zero.
  - Digit 0 is never suppressed.
  - dp still follows `dp_mask`.
  - `dig_n` scanning is unchanged.
- **Undefined:** all eight digits always show their hex value.

## Test plan
Benches use `CLK_DIV`=8 and `BLANK_CYC`=2.
- **Reset:** hold `rstn`=0 for 3 cycles with `enable`=1 → `seg_n`=FF, `dig_n`=FF, `frame_done`=0 throughout. After release, `dig_n`=FE for 6 cycles beginning 3 cycles later.
- **Frame content:** `data`=32'h89AB_CDEF, `dp_mask`=0 → per digit, `seg_n` = 8E, 86, A1, C6, 83, 88, 90, 80 for digits 0..7. `frame_done` pulses once every 64 cycles.
- **Tearing:** change `data` from 0000_0000 to FFFF_FFFF while digit 3 is ON → remaining digits of the frame show C0. The next frame shows 8E on all digits.
- **Decimal point:** `dp_mask`=8'h01 with `data`=0 → digit 0 shows `seg_n`=40. All other digits show C0.
- **Enable drop:** deassert `enable` during digit 5 ON → outputs FF next cycle and no `frame_done`. Re-enable → scan restarts at digit 0 with a fresh shadow load.
- **Leading-zero suppression:** with `SEG_SCAN_LZS_EN` and `data`=32'h0000_0120 → digits 7..3 show FF, digits 2..0 show F9, A4, C0. Without the macro, digits 7..3 show C0.
